// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART receive front end. Turns an asynchronous serial line into byte
// strobes for the sector-buffer FIFO. It validates the start bit, checks the
// stop bit, flags framing errors and keeps a running count of good bytes.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   rx         in   serial line, idles high, asynchronous to sys_clk
//   rx_data    out  [7:0] last good byte (LSB first on the line); held
//   rx_flag    out  one-cycle strobe, rx_data valid
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   rx_busy    out  high in START, DATA and STOP
//   byte_cnt   out  [15:0] good bytes since reset, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned UART_BPS = 9600
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_flag,
    output logic        frame_err,
    output logic        rx_busy,
    output logic [15:0] byte_cnt
);

    // Clocks per bit and the mid-bit sample point derived from it.
    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] SAMPLE_PT = CNT_W'(BAUD_CNT_MAX / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_s3;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift_reg;
    logic [7:0]       r_rx_data;
    logic             r_rx_flag;
    logic             r_frame_err;
    logic             r_rx_busy;
    logic [15:0]      r_byte_cnt;

    logic             w_start_edge;
    logic             w_sample;
    logic             w_shift_en;
    logic             w_good;
    logic             w_ferr;
    logic             w_next_busy;

    // Two-flop synchroniser plus an edge-detect flop; preset high so reset
    // never looks like a falling edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_start_edge = r_rx_s3 & ~r_rx_s2;
    assign w_sample     = (r_baud_cnt == SAMPLE_PT);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_good       = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                // A line that is high again at mid-start was only a glitch.
                if (w_sample) begin
                    w_next_state = r_rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_sample) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a start edge half a bit later is caught.
                if (w_sample) begin
                    if (r_rx_s2) begin
                        w_good       = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_next_state = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Ignore the held-low line until it returns high.
                if (r_rx_s2) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_next_busy = (w_next_state == ST_START) ||
                         (w_next_state == ST_DATA)  ||
                         (w_next_state == ST_STOP);

    // Bit-period counter; parked at 0 whenever the FSM is (or becomes) idle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
        end else if ((r_state == ST_IDLE) || (w_next_state == ST_IDLE)) begin
            r_baud_cnt <= '0;
        end else if (r_baud_cnt == CNT_LAST) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
    end

    // Data bit index and shift register, bit 0 first.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_bit_idx   <= 3'd0;
            r_shift_reg <= 8'h00;
        end else if (r_state == ST_START) begin
            r_bit_idx <= 3'd0;
        end else if (w_shift_en) begin
            r_shift_reg[r_bit_idx] <= r_rx_s2;
            r_bit_idx              <= r_bit_idx + 3'd1;
        end
    end

    // Registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_data   <= 8'h00;
            r_rx_flag   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
            r_byte_cnt  <= 16'h0000;
        end else begin
            r_rx_flag   <= w_good;
            r_frame_err <= w_ferr;
            r_rx_busy   <= w_next_busy;
            if (w_good) begin
                r_rx_data  <= r_shift_reg;
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_flag   = r_rx_flag;
    assign frame_err = r_frame_err;
    assign rx_busy   = r_rx_busy;
    assign byte_cnt  = r_byte_cnt;

endmodule
